complement_unit_arbiter: RTL and testbench

COMPLEMENT_UNIT_ARBITER -- requirements
Module: complement_unit_arbiter

---
 rtl/complement_unit_arbiter.sv | 153 +++++++++++++++
 tb/tb_complement_unit_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/complement_unit_arbiter.sv
// Two-requester round-robin arbiter sharing one complement unit; one transaction in flight.
// Optional WAIT watchdog (ERR state, err flag) is compiled in by defining ARB_WATCHDOG_EN.
module complement_unit_arbiter #(
  parameter int unsigned TIMEOUT  = 8,
  parameter logic        CI_VALUE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic       req1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic [3:0] result,
  output logic       err,
  output logic       busy,
  output logic       unit_sel,
  output logic [3:0] unit_a,
  output logic [3:0] unit_b,
  output logic       unit_ci,
  input  logic [3:0] unit_sum,
  input  logic       unit_finish
);

  if (TIMEOUT < 2 || TIMEOUT > 15) begin : g_timeout_range
    $error("complement_unit_arbiter: TIMEOUT must be in 2..15");
  end

`ifdef ARB_WATCHDOG_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;
`endif

  state_t     state_q, state_d;
  logic [3:0] opa_q, opa_d;
  logic [3:0] opb_q, opb_d;
  logic       gnt_q, gnt_d;
  logic       last_q, last_d;
  logic [3:0] result_q, result_d;
  logic       win;
  logic       ack_phase;

`ifdef ARB_WATCHDOG_EN
  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);
  logic [3:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      result_q <= '0;
`ifdef ARB_WATCHDOG_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      result_q <= result_d;
`ifdef ARB_WATCHDOG_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    result_d = result_q;
    win      = 1'b0;
`ifdef ARB_WATCHDOG_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not granted last wins.
          win    = (req0 && req1) ? ~last_q : req1;
          gnt_d  = win;
          last_d = win;
          opa_d  = win ? a1 : a0;
          opb_d  = win ? b1 : b0;
`ifdef ARB_WATCHDOG_EN
          err_d  = 1'b0;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
`ifdef ARB_WATCHDOG_EN
        cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (unit_finish) begin
          result_d = unit_sum;
          state_d  = S_DONE;
        end
`ifdef ARB_WATCHDOG_EN
        else if (cnt_q == CNT_LAST) begin
          // Flag and clear result on entry so ERR presents them with its ack.
          err_d    = 1'b1;
          result_d = '0;
          state_d  = S_ERR;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
      S_DONE: state_d = S_IDLE;
`ifdef ARB_WATCHDOG_EN
      S_ERR:  state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ARB_WATCHDOG_EN
  assign ack_phase = (state_q == S_DONE) || (state_q == S_ERR);
  assign err       = err_q;
`else
  assign ack_phase = (state_q == S_DONE);
  assign err       = 1'b0;
`endif

  assign ack0     = ack_phase && !gnt_q;
  assign ack1     = ack_phase &&  gnt_q;
  assign busy     = (state_q != S_IDLE);
  assign unit_sel = (state_q == S_START);
  assign unit_a   = opa_q;
  assign unit_b   = opb_q;
  assign unit_ci  = CI_VALUE;
  assign result   = result_q;

endmodule

// File: tb/tb_complement_unit_arbiter.sv
// Directed bench for complement_unit_arbiter with a behavioural two-cycle complement unit.
// Watchdog scenario is exercised when ARB_WATCHDOG_EN is defined; otherwise the endless-WAIT case.
module tb_complement_unit_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic       ack0, ack1, err, busy, unit_sel, unit_ci, unit_finish;
  logic [3:0] result, unit_a, unit_b, unit_sum;
  logic       fin_en;

  int checks = 0;
  int errors = 0;

  complement_unit_arbiter #(.TIMEOUT(8), .CI_VALUE(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .result(result), .err(err), .busy(busy),
    .unit_sel(unit_sel), .unit_a(unit_a), .unit_b(unit_b), .unit_ci(unit_ci),
    .unit_sum(unit_sum), .unit_finish(unit_finish)
  );

  always #5 clk = ~clk;

  // Complement unit: negative values become sign-magnitude, finish two cycles after sel.
  function automatic logic [3:0] cu(input logic [3:0] a, input logic [3:0] b);
    return a[3] ? (4'b1000 | ((~a + b) & 4'b0111)) : a;
  endfunction

  logic       sel_d1, sel_d2;
  logic [3:0] sum_lat;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_d1  <= 1'b0;
      sel_d2  <= 1'b0;
      sum_lat <= '0;
    end else begin
      sel_d1 <= unit_sel;
      sel_d2 <= sel_d1;
      if (unit_sel) sum_lat <= cu(unit_a, unit_b);
    end
  end
  assign unit_finish = sel_d2 & fin_en;
  assign unit_sum    = sum_lat;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({ack0, ack1} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b want 00", {ack0, ack1}); end
    checks++; if (unit_sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b want 0", unit_sel); end
    checks++; if (result !== 4'd0) begin errors++; $display("FAIL reset_result: got %b want 0000", result); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if ({unit_a, unit_b} !== 8'd0) begin errors++; $display("FAIL reset_operands: got %b want 00000000", {unit_a, unit_b}); end
    checks++; if (unit_ci !== 1'b0) begin errors++; $display("FAIL reset_ci: got %b want 0", unit_ci); end
  endtask

  task automatic test_single;
    req0 = 1'b1; a0 = 4'b1011; b0 = 4'b0001;
    step;
    checks++; if (unit_sel !== 1'b1) begin errors++; $display("FAIL single_sel: got %b want 1", unit_sel); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    checks++; if ({unit_a, unit_b} !== 8'b1011_0001) begin errors++; $display("FAIL single_operands: got %b want 10110001", {unit_a, unit_b}); end
    req0 = 1'b0;
    step;
    checks++; if ({unit_sel, ack0} !== 2'b00) begin errors++; $display("FAIL single_n1: got sel/ack0 %b want 00", {unit_sel, ack0}); end
    step;
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL single_n2_ack0: got %b want 0", ack0); end
    step;
    checks++; if ({ack0, ack1} !== 2'b10) begin errors++; $display("FAIL single_ack: got %b want 10", {ack0, ack1}); end
    checks++; if (result !== 4'b1101) begin errors++; $display("FAIL single_result: got %b want 1101", result); end
    step;
    checks++; if ({ack0, busy} !== 2'b00) begin errors++; $display("FAIL single_after: got ack0/busy %b want 00", {ack0, busy}); end
    checks++; if (result !== 4'b1101) begin errors++; $display("FAIL single_hold: got %b want 1101", result); end
  endtask

  task automatic test_tie;
    logic got;
    logic overlap;
    rst = 1'b1; step; rst = 1'b0;
    req0 = 1'b1; a0 = 4'b0011; b0 = 4'b0001;
    req1 = 1'b1; a1 = 4'b0101; b1 = 4'b0001;
    step;
    checks++; if ({unit_sel, unit_a} !== 5'b1_0011) begin errors++; $display("FAIL tie_first_grant: got sel/a %b want 10011", {unit_sel, unit_a}); end
    req0 = 1'b0;
    got = 1'b0; overlap = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step;
      if (ack0 && ack1) overlap = 1'b1;
      if (ack0) got = 1'b1;
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL tie_ack0_timeout: got %b want 1", got); end
    checks++; if (result !== 4'b0011) begin errors++; $display("FAIL tie_result0: got %b want 0011", result); end
    step;
    checks++; if ({busy, ack1} !== 2'b00) begin errors++; $display("FAIL tie_idle_gap: got busy/ack1 %b want 00", {busy, ack1}); end
    step;
    checks++; if ({unit_sel, unit_a} !== 5'b1_0101) begin errors++; $display("FAIL tie_second_grant: got sel/a %b want 10101", {unit_sel, unit_a}); end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step;
      if (ack0 && ack1) overlap = 1'b1;
      if (ack1) got = 1'b1;
    end
    req1 = 1'b0;
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL tie_ack1_timeout: got %b want 1", got); end
    checks++; if (result !== 4'b0101) begin errors++; $display("FAIL tie_result1: got %b want 0101", result); end
    checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL tie_ack_overlap: got %b want 0", overlap); end
    step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tie_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int sel_cnt = 0, ack_cnt = 0, last_sel = -1, bad_gap = 0, ack0_cnt = 0;
    req1 = 1'b1; a1 = 4'b1110; b1 = 4'b0001;
    for (int k = 1; k <= 24; k++) begin
      step;
      if (unit_sel) begin
        if (last_sel >= 0 && (k - last_sel) != 5) bad_gap++;
        last_sel = k;
        sel_cnt++;
      end
      if (ack1) ack_cnt++;
      if (ack0) ack0_cnt++;
    end
    req1 = 1'b0;
    checks++; if (sel_cnt !== 5) begin errors++; $display("FAIL b2b_sel_count: got %0d want 5", sel_cnt); end
    checks++; if (ack_cnt !== 5) begin errors++; $display("FAIL b2b_ack1_count: got %0d want 5", ack_cnt); end
    checks++; if (bad_gap !== 0) begin errors++; $display("FAIL b2b_interval: got %0d bad gaps want 0", bad_gap); end
    checks++; if (ack0_cnt !== 0) begin errors++; $display("FAIL b2b_ack0: got %0d want 0", ack0_cnt); end
    checks++; if (result !== 4'b1010) begin errors++; $display("FAIL b2b_result: got %b want 1010", result); end
    step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_drop;
    logic got = 1'b0;
    req0 = 1'b1; a0 = 4'b1001; b0 = 4'b0001;
    step;
    checks++; if (unit_a !== 4'b1001) begin errors++; $display("FAIL drop_grant_a: got %b want 1001", unit_a); end
    req0 = 1'b0; a0 = 4'b0010; b0 = 4'b0000;
    step;
    checks++; if ({unit_a, unit_b} !== 8'b1001_0001) begin errors++; $display("FAIL drop_held_operands: got %b want 10010001", {unit_a, unit_b}); end
    for (int i = 0; i < 10 && !got; i++) begin
      step;
      if (ack0) got = 1'b1;
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL drop_ack0_timeout: got %b want 1", got); end
    checks++; if (result !== 4'b1111) begin errors++; $display("FAIL drop_result: got %b want 1111", result); end
    step;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_end_busy: got %b want 0", busy); end
  endtask

`ifdef ARB_WATCHDOG_EN
  task automatic test_watchdog;
    int early = 0;
    logic got = 1'b0;
    fin_en = 1'b0;
    req0 = 1'b1; a0 = 4'b0110; b0 = 4'b0001;
    step;
    req0 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step;
      if (ack0 || !busy) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL wd_early: got %0d early events want 0", early); end
    step;
    checks++; if ({ack0, err} !== 2'b11) begin errors++; $display("FAIL wd_err_ack: got ack0/err %b want 11", {ack0, err}); end
    checks++; if (result !== 4'd0) begin errors++; $display("FAIL wd_result: got %b want 0000", result); end
    step;
    checks++; if ({busy, ack0} !== 2'b00) begin errors++; $display("FAIL wd_after: got busy/ack0 %b want 00", {busy, ack0}); end
    fin_en = 1'b1;
    req0 = 1'b1; a0 = 4'b0100; b0 = 4'b0001;
    step;
    req0 = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd_err_clear: got %b want 0", err); end
    for (int i = 0; i < 10 && !got; i++) begin
      step;
      if (ack0) got = 1'b1;
    end
    checks++; if ({got, result} !== 5'b1_0100) begin errors++; $display("FAIL wd_recover: got ack/result %b want 10100", {got, result}); end
    step;
  endtask
`else
  task automatic test_wait_forever;
    int acks = 0, idle = 0;
    fin_en = 1'b0;
    req0 = 1'b1; a0 = 4'b0110; b0 = 4'b0001;
    step;
    req0 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step;
      if (ack0 || ack1) acks++;
      if (!busy) idle++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL wait_acks: got %0d want 0", acks); end
    checks++; if (idle !== 0) begin errors++; $display("FAIL wait_idle: got %0d idle cycles want 0", idle); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wait_err: got %b want 0", err); end
    rst = 1'b1; step; rst = 1'b0; fin_en = 1'b1;
  endtask
`endif

  task automatic test_reset_mid_wait;
    fin_en = 1'b0;
    req0 = 1'b1; a0 = 4'b1011; b0 = 4'b0001;
    step;
    req0 = 1'b0;
    step; step;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstwait_pre_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++; if ({busy, ack0, ack1, unit_sel} !== 4'b0000) begin errors++; $display("FAIL rstwait_async: got busy/ack0/ack1/sel %b want 0000", {busy, ack0, ack1, unit_sel}); end
    step;
    checks++; if ({busy, ack0, ack1, unit_sel} !== 4'b0000) begin errors++; $display("FAIL rstwait_next: got busy/ack0/ack1/sel %b want 0000", {busy, ack0, ack1, unit_sel}); end
    checks++; if (result !== 4'd0) begin errors++; $display("FAIL rstwait_result: got %b want 0000", result); end
    rst = 1'b0; fin_en = 1'b1;
    step;
    checks++; if ({busy, ack0} !== 2'b00) begin errors++; $display("FAIL rstwait_no_ack: got busy/ack0 %b want 00", {busy, ack0}); end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; fin_en = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    step; step;
    test_reset;
    rst = 1'b0;
    test_single;
    test_tie;
    test_back_to_back;
    test_drop;
`ifdef ARB_WATCHDOG_EN
    test_watchdog;
`else
    test_wait_forever;
`endif
    test_reset_mid_wait;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
